// File: rtl/fisr_req_arbiter.sv
// Round-robin, credit-flow-controlled front end sharing one pipelined
// inverse-square-root core among NREQ requesters, with per-requester FIFOs.
module fisr_req_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 32,
  parameter int CORE_LAT  = 8,
  parameter int RSP_DEPTH = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic                     core_in_valid,
  output logic [DATA_W-1:0]        core_in_data,
  input  logic                     core_out_valid,
  input  logic [DATA_W-1:0]        core_out_data,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [NREQ*DATA_W-1:0]   rsp_data,
  output logic                     err_orphan
);

  localparam int TW = $clog2(NREQ);
  localparam int AW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int MW = $clog2(CORE_LAT + 1);

  logic [TW-1:0]     rr_ptr;
  logic [TW-1:0]     grant_idx;
  logic [TW-1:0]     cand;
  logic [TW-1:0]     in_tag;
  logic              grant_any;
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   pop;
  logic [NREQ-1:0]   wr_en;
  logic [NREQ-1:0]   drop;
  logic [CW-1:0]     credit [NREQ];
  logic              pipe_v [CORE_LAT];
  logic [TW-1:0]     pipe_t [CORE_LAT];
  logic              tail_v;
  logic [TW-1:0]     tail_t;
  logic [DATA_W-1:0] mem [NREQ][RSP_DEPTH];
  logic [AW:0]       wr_ptr [NREQ];
  logic [AW:0]       rd_ptr [NREQ];
  logic [MW-1:0]     mask_cnt;
  logic              orphan;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] & (credit[i] != '0);
    end
    for (int k = 0; k < NREQ; k++) begin
      cand = TW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_any && elig[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    grant = (grant_any && ARESETN) ? (NREQ'(1) << grant_idx) : '0;
  end

  assign req_ready = grant;
  assign tail_v    = pipe_v[CORE_LAT-1];
  assign tail_t    = pipe_t[CORE_LAT-1];

  // Orphan results right after reset belong to pre-reset issues; mask them.
  assign orphan = (core_out_valid & ~tail_v & (mask_cnt == '0))
                | (tail_v & ~core_out_valid);

  always_comb begin
    rsp_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = wr_ptr[i] != rd_ptr[i];
      pop[i]       = rsp_valid[i] & rsp_ready[i];
      wr_en[i]     = core_out_valid & tail_v & (tail_t == TW'(i));
      drop[i]      = ~core_out_valid & tail_v & (tail_t == TW'(i));
      rsp_data[i*DATA_W +: DATA_W] = mem[i][rd_ptr[i][AW-1:0]];
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rr_ptr        <= '0;
      core_in_valid <= 1'b0;
      core_in_data  <= '0;
      in_tag        <= '0;
      err_orphan    <= 1'b0;
      mask_cnt      <= MW'(CORE_LAT);
      for (int k = 0; k < CORE_LAT; k++) begin
        pipe_v[k] <= 1'b0;
        pipe_t[k] <= '0;
      end
    end else begin
      core_in_valid <= grant_any;
      if (grant_any) begin
        rr_ptr       <= (grant_idx == TW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
        core_in_data <= req_data[grant_idx*DATA_W +: DATA_W];
        in_tag       <= grant_idx;
      end
      pipe_v[0] <= core_in_valid;
      pipe_t[0] <= in_tag;
      for (int k = 1; k < CORE_LAT; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_t[k] <= pipe_t[k-1];
      end
      if (mask_cnt != '0) mask_cnt <= mask_cnt - 1'b1;
      if (orphan) err_orphan <= 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!ARESETN) begin
        credit[i] <= CW'(RSP_DEPTH);
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        for (int d = 0; d < RSP_DEPTH; d++) mem[i][d] <= '0;
      end else begin
        credit[i] <= credit[i] - CW'(grant[i]) + CW'(pop[i]) + CW'(drop[i]);
        if (wr_en[i]) begin
          mem[i][wr_ptr[i][AW-1:0]] <= core_out_data;
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        end
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fisr_req_arbiter.sv
// Directed bench for fisr_req_arbiter with an echo-plus-one core model.
module tb_fisr_req_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int LAT  = 8;

  logic                 ACLK = 1'b0;
  logic                 ARESETN = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic                 core_in_valid;
  logic [DW-1:0]        core_in_data;
  logic                 core_out_valid;
  logic [DW-1:0]        core_out_data;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready = '0;
  logic [NREQ*DW-1:0]   rsp_data;
  logic                 err_orphan;

  int total = 0;
  int bad   = 0;

  fisr_req_arbiter #(.NREQ(NREQ), .DATA_W(DW), .CORE_LAT(LAT), .RSP_DEPTH(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .core_in_valid(core_in_valid), .core_in_data(core_in_data),
    .core_out_valid(core_out_valid), .core_out_data(core_out_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .err_orphan(err_orphan)
  );

  always #5 ACLK = ~ACLK;

  logic          mv [LAT];
  logic [DW-1:0] md [LAT];
  logic          inject = 1'b0;

  initial for (int k = 0; k < LAT; k++) begin mv[k] = 1'b0; md[k] = '0; end

  always @(posedge ACLK) begin
    mv[0] <= core_in_valid;
    md[0] <= core_in_data + 1;
    for (int k = 1; k < LAT; k++) begin
      mv[k] <= mv[k-1];
      md[k] <= md[k-1];
    end
  end

  assign core_out_valid = mv[LAT-1] | inject;
  assign core_out_data  = md[LAT-1];

  task automatic step;
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset;
    ARESETN = 1'b0;
    req_valid = '1;
    req_data = {32'h4, 32'h3, 32'h2, 32'h1};
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (req_ready !== 4'b0) begin
        bad++; $display("FAIL rst_req_ready c=%0d got %b want 0000", c, req_ready);
      end
      total++;
      if (core_in_valid !== 1'b0) begin
        bad++; $display("FAIL rst_core_in_valid c=%0d got %b want 0", c, core_in_valid);
      end
      total++;
      if (rsp_valid !== 4'b0) begin
        bad++; $display("FAIL rst_rsp_valid c=%0d got %b want 0000", c, rsp_valid);
      end
      total++;
      if (err_orphan !== 1'b0) begin
        bad++; $display("FAIL rst_err c=%0d got %b want 0", c, err_orphan);
      end
    end
    total++;
    if (rsp_data !== '0 || core_in_data !== '0) begin
      bad++; $display("FAIL rst_data got %h/%h want 0", rsp_data, core_in_data);
    end
    req_valid = '0;
    ARESETN = 1'b1;
    step();
  endtask

  task automatic test_single;
    logic [NREQ-1:0] exp;
    rsp_ready = '0;
    req_data[2*DW +: DW] = 32'h0001_0000;
    req_valid = 4'b0100;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++; $display("FAIL single_grant got %b want 0100", req_ready);
    end
    step();
    req_valid = '0;
    total++;
    if (core_in_valid !== 1'b1 || core_in_data !== 32'h0001_0000) begin
      bad++; $display("FAIL single_issue got %b/%h want 1/00010000", core_in_valid, core_in_data);
    end
    for (int k = 2; k <= LAT + 2; k++) begin
      step();
      exp = (k == LAT + 2) ? 4'b0100 : 4'b0000;
      total++;
      if (rsp_valid !== exp) begin
        bad++; $display("FAIL single_rsp_valid k=%0d got %b want %b", k, rsp_valid, exp);
      end
    end
    total++;
    if (rsp_data[2*DW +: DW] !== 32'h0001_0001) begin
      bad++; $display("FAIL single_rsp_data got %h want 00010001", rsp_data[2*DW +: DW]);
    end
    rsp_ready = 4'b0100;
    step();
    rsp_ready = '0;
    total++;
    if (rsp_valid !== 4'b0) begin
      bad++; $display("FAIL single_pop got %b want 0000", rsp_valid);
    end
  endtask

  task automatic test_round_robin;
    int cnt [NREQ];
    logic [NREQ-1:0] exp;
    ARESETN = 1'b0;
    step();
    ARESETN = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      cnt[i] = 0;
      req_data[i*DW +: DW] = 32'hA000_0000 + i;
    end
    req_valid = '1;
    rsp_ready = '1;
    for (int c = 0; c < 16; c++) begin
      #1;
      exp = 4'b0001 << (c % 4);
      total++;
      if (req_ready !== exp) begin
        bad++; $display("FAIL rr_grant c=%0d got %b want %b", c, req_ready, exp);
      end
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) cnt[i]++;
      step();
    end
    for (int i = 0; i < NREQ; i++) begin
      total++;
      if (cnt[i] !== 4) begin
        bad++; $display("FAIL rr_share req=%0d got %0d want 4", i, cnt[i]);
      end
    end
    req_valid = '0;
    repeat (14) step();
    total++;
    if (rsp_valid !== 4'b0 || err_orphan !== 1'b0) begin
      bad++; $display("FAIL rr_drain got %b/%b want 0000/0", rsp_valid, err_orphan);
    end
    rsp_ready = '0;
  endtask

  task automatic test_credit_stall;
    logic [DW-1:0] d;
    logic a;
    int acc;
    rsp_ready = '0;
    d = 32'h100;
    req_data[DW +: DW] = d;
    req_valid = 4'b0010;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      a = req_ready[1];
      step();
      if (a) begin acc++; d = d + 1; req_data[DW +: DW] = d; end
    end
    total++;
    if (acc !== 4) begin
      bad++; $display("FAIL credit_accepts got %0d want 4", acc);
    end
    #1;
    total++;
    if (req_ready[1] !== 1'b0) begin
      bad++; $display("FAIL credit_stall got %b want 0", req_ready[1]);
    end
    total++;
    if (rsp_valid[1] !== 1'b1 || rsp_data[DW +: DW] !== 32'h101) begin
      bad++; $display("FAIL credit_head got %b/%h want 1/00000101", rsp_valid[1], rsp_data[DW +: DW]);
    end
    rsp_ready = 4'b0010;
    step();
    rsp_ready = '0;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      a = req_ready[1];
      step();
      if (a) begin acc++; d = d + 1; req_data[DW +: DW] = d; end
    end
    total++;
    if (acc !== 1) begin
      bad++; $display("FAIL credit_refill got %0d want 1", acc);
    end
    req_valid = '0;
    rsp_ready = 4'b0010;
    for (int n = 0; n < 4; n++) begin
      #1;
      total++;
      if (rsp_valid[1] !== 1'b1 || rsp_data[DW +: DW] !== 32'h102 + n) begin
        bad++; $display("FAIL credit_order n=%0d got %b/%h want 1/%h", n, rsp_valid[1], rsp_data[DW +: DW], 32'h102 + n);
      end
      step();
    end
    total++;
    if (rsp_valid !== 4'b0) begin
      bad++; $display("FAIL credit_empty got %b want 0000", rsp_valid);
    end
    rsp_ready = '0;
  endtask

  task automatic test_reset_midflight;
    logic seen_rsp;
    logic seen_err;
    int acc;
    rsp_ready = '0;
    req_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      req_data[0 +: DW] = 32'h200 + c;
      #1;
      total++;
      if (req_ready !== 4'b0001) begin
        bad++; $display("FAIL mid_issue c=%0d got %b want 0001", c, req_ready);
      end
      step();
    end
    ARESETN = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b0) begin
      bad++; $display("FAIL mid_rst_ready got %b want 0000", req_ready);
    end
    step();
    ARESETN = 1'b1;
    req_valid = '0;
    seen_rsp = 1'b0;
    seen_err = 1'b0;
    for (int c = 0; c < 25; c++) begin
      step();
      seen_rsp = seen_rsp | (|rsp_valid);
      seen_err = seen_err | err_orphan;
    end
    total++;
    if (seen_rsp !== 1'b0 || seen_err !== 1'b0) begin
      bad++; $display("FAIL mid_quiet got rsp=%b err=%b want 0/0", seen_rsp, seen_err);
    end
    acc = 0;
    req_valid = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready[0]) acc++;
      step();
    end
    total++;
    if (acc !== 4) begin
      bad++; $display("FAIL mid_credits got %0d want 4", acc);
    end
    req_valid = '0;
    rsp_ready = 4'b0001;
    repeat (16) step();
    rsp_ready = '0;
    total++;
    if (rsp_valid !== 4'b0 || err_orphan !== 1'b0) begin
      bad++; $display("FAIL mid_drain got %b/%b want 0000/0", rsp_valid, err_orphan);
    end
  endtask

  task automatic test_orphan;
    logic seen_rsp;
    logic all_err;
    #1;
    total++;
    if (err_orphan !== 1'b0) begin
      bad++; $display("FAIL orphan_pre got %b want 0", err_orphan);
    end
    inject = 1'b1;
    step();
    inject = 1'b0;
    total++;
    if (err_orphan !== 1'b1) begin
      bad++; $display("FAIL orphan_set got %b want 1", err_orphan);
    end
    seen_rsp = 1'b0;
    all_err = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      seen_rsp = seen_rsp | (|rsp_valid);
      all_err = all_err & err_orphan;
    end
    total++;
    if (all_err !== 1'b1) begin
      bad++; $display("FAIL orphan_sticky got %b want 1", all_err);
    end
    total++;
    if (seen_rsp !== 1'b0) begin
      bad++; $display("FAIL orphan_nowrite got %b want 0", seen_rsp);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_credit_stall();
    test_reset_midflight();
    test_orphan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
